rtc_hms_core: RTL and testbench

- Parametrised single-clock time-of-day core: hours/minutes/seconds in BCD, derived from the system clock by an internal prescaler.
- Uses clock enables instead of ripple-derived clocks; the whole block runs on one clock.
- Adds what the earlier counter chain lacks: full HH:MM:SS parallel load with validity check, per-field increment buttons, 12/24-hour display mode, and a minute-resolution alarm.
- Its BCD outputs feed the existing 4-digit display scanner unchanged.

---
 rtl/rtc_hms_core.sv | 194 +++++++++++++++++++
 tb/tb_rtc_hms_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_hms_core.sv
// rtc_hms_core: single-clock HH:MM:SS time-of-day core in BCD.
// A prescaler turns the system clock into a one-cycle sec_tick enable.
// Time is kept internally in 24 h BCD; 12 h presentation is derived
// combinationally. It also provides a validated parallel load,
// per-field increments and a minute-resolution alarm with a hold counter.
module rtc_hms_core #(
    parameter int CLK_HZ    = 50000000,
    parameter int ALARM_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] ld_hour_h,
    input  logic [3:0] ld_hour_l,
    input  logic [2:0] ld_min_h,
    input  logic [3:0] ld_min_l,
    input  logic [2:0] ld_sec_h,
    input  logic [3:0] ld_sec_l,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic [1:0] alm_hour_h,
    input  logic [3:0] alm_hour_l,
    input  logic [2:0] alm_min_h,
    input  logic [3:0] alm_min_l,
    output logic [3:0] sec_l,
    output logic [2:0] sec_h,
    output logic [3:0] min_l,
    output logic [2:0] min_h,
    output logic [3:0] hour_l,
    output logic [1:0] hour_h,
    output logic       pm,
    output logic       sec_tick,
    output logic       sec_flash,
    output logic       alarm,
    output logic       load_err
);

    localparam int DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int ALM_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);
    localparam logic [ALM_W-1:0] ALM_LOAD = ALM_W'(ALARM_SEC);

    // Seconds/minutes style BCD increment: {wrap, tens, units}.
    function automatic logic [7:0] bcd60_inc(input logic [2:0] h, input logic [3:0] l);
        if (l != 4'd9)      return {1'b0, h, l + 4'd1};
        else if (h != 3'd5) return {1'b0, h + 3'd1, 4'd0};
        else                return 8'h80;
    endfunction

    // 24 h BCD hour increment: {tens, units}, 23 wraps to 00.
    function automatic logic [5:0] hour_inc(input logic [1:0] h, input logic [3:0] l);
        if (h == 2'd2 && l == 4'd3) return 6'd0;
        else if (l == 4'd9)         return {h + 2'd1, 4'd0};
        else                        return {h, l + 4'd1};
    endfunction

    logic [DIV_W-1:0] div_q, div_n;
    logic [ALM_W-1:0] alm_cnt_q;
    logic [1:0] hr_h_q, hr_h_n;
    logic [3:0] hr_l_q, hr_l_n;
    logic [2:0] min_h_n, sec_h_n;
    logic [3:0] min_l_n, sec_l_n;
    logic [7:0] s_inc, m_inc;
    logic [5:0] h_inc;
    logic       ld_valid, any_inc, tick_adv, alarm_hit;
    logic [4:0] hour_bin, h12, h12_disp;

    assign sec_tick  = (div_q == DIV_MAX);
    assign sec_flash = (div_q < DIV_HALF);

    assign ld_valid = (ld_sec_l <= 4'd9) && (ld_sec_h <= 3'd5) &&
                      (ld_min_l <= 4'd9) && (ld_min_h <= 3'd5) &&
                      (ld_hour_l <= 4'd9) &&
                      ((ld_hour_h < 2'd2) || (ld_hour_h == 2'd2 && ld_hour_l <= 4'd3));

    // A tick only advances time when no load or increment claims the edge.
    assign any_inc  = inc_min | inc_hour;
    assign tick_adv = sec_tick & ~load & ~any_inc;

    assign s_inc = bcd60_inc(sec_h, sec_l);
    assign m_inc = bcd60_inc(min_h, min_l);
    assign h_inc = hour_inc(hr_h_q, hr_l_q);

    // Next-time selection: load > increments > tick carry chain.
    always_comb begin
        sec_h_n = sec_h;
        sec_l_n = sec_l;
        min_h_n = min_h;
        min_l_n = min_l;
        hr_h_n  = hr_h_q;
        hr_l_n  = hr_l_q;
        if (load) begin
            if (ld_valid) begin
                sec_h_n = ld_sec_h;
                sec_l_n = ld_sec_l;
                min_h_n = ld_min_h;
                min_l_n = ld_min_l;
                hr_h_n  = ld_hour_h;
                hr_l_n  = ld_hour_l;
            end
        end else if (any_inc) begin
            if (inc_min) begin
                min_h_n = m_inc[6:4];
                min_l_n = m_inc[3:0];
            end
            if (inc_hour) begin
                hr_h_n = h_inc[5:4];
                hr_l_n = h_inc[3:0];
            end
        end else if (sec_tick) begin
            sec_h_n = s_inc[6:4];
            sec_l_n = s_inc[3:0];
            if (s_inc[7]) begin
                min_h_n = m_inc[6:4];
                min_l_n = m_inc[3:0];
                if (m_inc[7]) begin
                    hr_h_n = h_inc[5:4];
                    hr_l_n = h_inc[3:0];
                end
            end
        end
    end

    // Prescaler restarts on a valid load so a full second follows it.
    always_comb begin
        div_n = div_q + DIV_W'(1);
        if (load && ld_valid)   div_n = '0;
        else if (sec_tick)      div_n = '0;
    end

    // Alarm fires only on a tick-driven advance into HH:MM:00.
    assign alarm_hit = tick_adv && alarm_en &&
                       (sec_h_n == 3'd0) && (sec_l_n == 4'd0) &&
                       (min_h_n == alm_min_h) && (min_l_n == alm_min_l) &&
                       (hr_h_n == alm_hour_h) && (hr_l_n == alm_hour_l);

    // Time, prescaler and load error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            sec_h    <= '0;
            sec_l    <= '0;
            min_h    <= '0;
            min_l    <= '0;
            hr_h_q   <= '0;
            hr_l_q   <= '0;
            load_err <= 1'b0;
        end else begin
            div_q    <= div_n;
            sec_h    <= sec_h_n;
            sec_l    <= sec_l_n;
            min_h    <= min_h_n;
            min_l    <= min_l_n;
            hr_h_q   <= hr_h_n;
            hr_l_q   <= hr_l_n;
            load_err <= load & ~ld_valid;
        end
    end

    // Alarm hold counter: reload on hit, count down on each tick.
    always_ff @(posedge clk) begin
        if (rst || !alarm_en) begin
            alarm     <= 1'b0;
            alm_cnt_q <= '0;
        end else if (alarm_hit) begin
            alarm     <= 1'b1;
            alm_cnt_q <= ALM_LOAD;
        end else if (sec_tick && alm_cnt_q != '0) begin
            alm_cnt_q <= alm_cnt_q - ALM_W'(1);
            if (alm_cnt_q == ALM_W'(1)) alarm <= 1'b0;
        end
    end

    // 12/24 h presentation derived from the internal 24 h hour.
    always_comb begin
        hour_bin = ({3'b000, hr_h_q} * 5'd10) + {1'b0, hr_l_q};
        pm       = (hour_bin >= 5'd12);
        if (hour_bin == 5'd0)       h12 = 5'd12;
        else if (hour_bin > 5'd12)  h12 = hour_bin - 5'd12;
        else                        h12 = hour_bin;
        h12_disp = (h12 >= 5'd10) ? (h12 - 5'd10) : h12;
        if (mode_12h) begin
            hour_h = (h12 >= 5'd10) ? 2'd1 : 2'd0;
            hour_l = h12_disp[3:0];
        end else begin
            hour_h = hr_h_q;
            hour_l = hr_l_q;
        end
    end

endmodule

// File: tb/tb_rtc_hms_core.sv
// tb_rtc_hms_core: directed checks of prescaler, carry chain, load
// validation, 12 h presentation, increments, alarm and reset.
module tb_rtc_hms_core;

    localparam int CLK_HZ    = 4;
    localparam int ALARM_SEC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [1:0] ld_hour_h = '0;
    logic [3:0] ld_hour_l = '0;
    logic [2:0] ld_min_h = '0;
    logic [3:0] ld_min_l = '0;
    logic [2:0] ld_sec_h = '0;
    logic [3:0] ld_sec_l = '0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       mode_12h = 1'b0;
    logic       alarm_en = 1'b0;
    logic [1:0] alm_hour_h = 2'd0;
    logic [3:0] alm_hour_l = 4'd7;
    logic [2:0] alm_min_h = 3'd3;
    logic [3:0] alm_min_l = 4'd0;
    logic [3:0] sec_l, min_l, hour_l;
    logic [2:0] sec_h, min_h;
    logic [1:0] hour_h;
    logic       pm, sec_tick, sec_flash, alarm, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_hms_core #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ld_hour_h(ld_hour_h), .ld_hour_l(ld_hour_l),
        .ld_min_h(ld_min_h), .ld_min_l(ld_min_l),
        .ld_sec_h(ld_sec_h), .ld_sec_l(ld_sec_l),
        .inc_min(inc_min), .inc_hour(inc_hour), .mode_12h(mode_12h),
        .alarm_en(alarm_en),
        .alm_hour_h(alm_hour_h), .alm_hour_l(alm_hour_l),
        .alm_min_h(alm_min_h), .alm_min_l(alm_min_l),
        .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h),
        .hour_l(hour_l), .hour_h(hour_h), .pm(pm),
        .sec_tick(sec_tick), .sec_flash(sec_flash),
        .alarm(alarm), .load_err(load_err)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] tpack(input int hh, input int mm, input int ss);
        return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [19:0] now();
        return {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
    endfunction

    task automatic load_raw(input int hh_h, input int hh_l, input int mm_h,
                            input int mm_l, input int ss_h, input int ss_l);
        ld_hour_h = 2'(hh_h); ld_hour_l = 4'(hh_l);
        ld_min_h  = 3'(mm_h); ld_min_l  = 4'(mm_l);
        ld_sec_h  = 3'(ss_h); ld_sec_l  = 4'(ss_l);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic load_time(input int hh, input int mm, input int ss);
        load_raw(hh / 10, hh % 10, mm / 10, mm % 10, ss / 10, ss % 10);
    endtask

    // Run up to and through the next tick edge (bounded).
    task automatic wait_tick();
        int n = 0;
        while (sec_tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("tick_timeout", 32'(n < 16), 32'd1);
        step();
    endtask

    initial begin
        // Reset and prescaler.
        step();
        step();
        rst = 1'b0;
        check("rst_time", 32'(now()), 32'(tpack(0, 0, 0)));
        check("rst_tick", 32'(sec_tick), 32'd0);
        check("rst_flash", 32'(sec_flash), 32'd1);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        mode_12h = 1'b1;
        #1;
        check("rst_hour12", 32'({hour_h, hour_l}), 32'h12);
        check("rst_pm", 32'(pm), 32'd0);
        mode_12h = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("pre_tick", 32'(sec_tick), 32'((k % 4) == 3));
            check("pre_flash", 32'(sec_flash), 32'((k % 4) < 2));
            check("pre_sec", 32'(sec_l), 32'(k / 4));
        end

        // Full carry chain and 12 h at midnight.
        load_time(23, 59, 58);
        wait_tick();
        check("t_235959", 32'(now()), 32'(tpack(23, 59, 59)));
        mode_12h = 1'b1;
        #1;
        check("h12_23", 32'({hour_h, hour_l}), 32'h11);
        check("pm_23", 32'(pm), 32'd1);
        mode_12h = 1'b0;
        wait_tick();
        check("t_wrap", 32'(now()), 32'(tpack(0, 0, 0)));
        mode_12h = 1'b1;
        #1;
        check("h12_00", 32'({hour_h, hour_l}), 32'h12);
        check("pm_00", 32'(pm), 32'd0);
        mode_12h = 1'b0;

        // Invalid loads: error pulse, time held, prescaler keeps counting.
        load_raw(2, 4, 0, 0, 0, 0);
        check("err24_pulse", 32'(load_err), 32'd1);
        check("err24_time", 32'(now()), 32'(tpack(0, 0, 0)));
        check("err24_flash1", 32'(sec_flash), 32'd1);
        step();
        check("err24_clear", 32'(load_err), 32'd0);
        check("err24_flash2", 32'(sec_flash), 32'd0);
        load_raw(1, 2, 6, 10, 0, 0);
        check("err6a_pulse", 32'(load_err), 32'd1);
        check("err6a_tick", 32'(sec_tick), 32'd1);
        check("err6a_time", 32'(now()), 32'(tpack(0, 0, 0)));
        step();
        check("err6a_clear", 32'(load_err), 32'd0);
        check("err6a_adv", 32'(now()), 32'(tpack(0, 0, 1)));

        // 12 h presentation.
        mode_12h = 1'b1;
        load_time(13, 5, 0);
        check("h12_13", 32'({hour_h, hour_l}), 32'h01);
        check("pm_13", 32'(pm), 32'd1);
        load_time(12, 0, 0);
        check("h12_12", 32'({hour_h, hour_l}), 32'h12);
        check("pm_12", 32'(pm), 32'd1);
        load_time(0, 30, 0);
        check("h12_0030", 32'({hour_h, hour_l}), 32'h12);
        check("pm_0030", 32'(pm), 32'd0);
        check("min_0030", 32'({min_h, min_l}), 32'h30);
        mode_12h = 1'b0;

        // Alarm: trigger, hold for ALARM_SEC ticks.
        alarm_en = 1'b1;
        load_time(7, 29, 59);
        check("alm_pre", 32'(alarm), 32'd0);
        wait_tick();
        check("alm_time", 32'(now()), 32'(tpack(7, 30, 0)));
        check("alm_on0", 32'(alarm), 32'd1);
        wait_tick();
        check("alm_on1", 32'(alarm), 32'd1);
        wait_tick();
        check("alm_on2", 32'(alarm), 32'd1);
        wait_tick();
        check("alm_off3", 32'(alarm), 32'd0);
        check("alm_t3", 32'(now()), 32'(tpack(7, 30, 3)));
        // Disarm clears on the next edge.
        load_time(7, 29, 59);
        wait_tick();
        check("alm2_on", 32'(alarm), 32'd1);
        wait_tick();
        check("alm2_on1", 32'(alarm), 32'd1);
        alarm_en = 1'b0;
        step();
        check("alm2_disarm", 32'(alarm), 32'd0);
        // Landing on the alarm time by load never triggers.
        alarm_en = 1'b1;
        load_time(7, 30, 0);
        check("alm_load", 32'(alarm), 32'd0);
        wait_tick();
        check("alm_load_t", 32'(now()), 32'(tpack(7, 30, 1)));
        check("alm_load_t_off", 32'(alarm), 32'd0);

        // Increments.
        load_time(0, 59, 30);
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        check("inc_min_wrap", 32'(now()), 32'(tpack(0, 0, 30)));
        load_time(23, 15, 0);
        inc_hour = 1'b1;
        step();
        inc_hour = 1'b0;
        check("inc_hour_wrap", 32'(now()), 32'(tpack(0, 15, 0)));
        for (int n = 0; n < 8 && sec_tick !== 1'b1; n++) step();
        check("inc_tick_ready", 32'(sec_tick), 32'd1);
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        check("inc_tick_drop", 32'(now()), 32'(tpack(0, 16, 0)));

        // Reset mid-count aborts alarm and restarts prescaler.
        load_time(7, 29, 59);
        wait_tick();
        check("rst_alm_on", 32'(alarm), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_time", 32'(now()), 32'(tpack(0, 0, 0)));
        check("rst2_alarm", 32'(alarm), 32'd0);
        check("rst2_flash", 32'(sec_flash), 32'd1);
        check("rst2_tick", 32'(sec_tick), 32'd0);
        step();
        step();
        step();
        check("rst2_tick3", 32'(sec_tick), 32'd1);
        step();
        check("rst2_sec1", 32'(now()), 32'(tpack(0, 0, 1)));
        check("rst2_alarm_off", 32'(alarm), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
